// File: rtl/jtframe_dwnld_split.sv
// ROM-download router: splits the ioctl byte stream into REGIONS memories, packing DW-bit words.
// Optional running checksum of accepted bytes when JTFRAME_DWNLD_CHECKSUM_EN is defined.
module jtframe_dwnld_split #(
  parameter int                      REGIONS = 4,
  parameter int                      AW      = 22,
  parameter int                      DW      = 16,
  parameter logic [REGIONS*AW-1:0]   START   = '0,
  parameter logic [AW-1:0]           TOTAL   = 'h10000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  downloading,
  input  logic [AW-1:0]         ioctl_addr,
  input  logic [7:0]            ioctl_data,
  input  logic                  ioctl_wr,
  output logic [REGIONS-1:0]    prog_we,
  output logic [AW-1:0]         prog_addr,
  output logic [DW-1:0]         prog_data,
  output logic [DW/8-1:0]       prog_be,
  output logic                  dwnld_busy,
  output logic                  dwnld_done,
  output logic                  overflow,
  output logic [15:0]           checksum
);
  localparam int BYTES = DW / 8;
  localparam int LB    = $clog2(BYTES);
  localparam int RW    = (REGIONS > 1) ? $clog2(REGIONS) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  // Highest region whose start does not exceed the address
  function automatic logic [RW-1:0] region_of(input logic [AW-1:0] a);
    region_of = '0;
    for (int i = 0; i < REGIONS; i++)
      if (a >= START[i*AW +: AW]) region_of = RW'(i);
  endfunction

  logic [1:0]       state;
  logic             dl_p1;
  logic             start_pend;
  logic [BYTES-1:0] pend_mask;
  logic [DW-1:0]    pend_data;
  logic [RW-1:0]    pend_reg;
  logic [AW-1:0]    pend_waddr;

  logic [RW-1:0]    in_reg;
  logic [AW-1:0]    in_start, local_addr, in_waddr;
  logic [BYTES-1:0] in_lane_bit, merged_mask, next_mask;
  logic [DW-1:0]    merged_data, emit_data;
  logic [BYTES-1:0] emit_mask;
  logic [RW-1:0]    emit_reg;
  logic [AW-1:0]    emit_addr;
  logic             in_range, accept, conflict, falling, rise, load_start, emit;

  always_comb begin
    rise        = downloading && !dl_p1;
    load_start  = (state == IDLE) && (rise || start_pend);
    in_reg      = region_of(ioctl_addr);
    in_start    = START[in_reg*AW +: AW];
    local_addr  = ioctl_addr - in_start;
    in_waddr    = local_addr >> LB;
    in_lane_bit = BYTES'(1) << (local_addr & AW'(BYTES-1));
    in_range    = ioctl_addr < TOTAL;
    accept      = (state == LOAD) && ioctl_wr && in_range;
    conflict    = accept && (|pend_mask) && (in_reg != pend_reg || in_waddr != pend_waddr);
    falling     = (state == LOAD) && !downloading;

    merged_mask = (conflict ? '0 : pend_mask) | (accept ? in_lane_bit : '0);
    merged_data = pend_data;
    for (int b = 0; b < BYTES; b++)
      if (accept && in_lane_bit[b]) merged_data[b*8 +: 8] = ioctl_data;

    emit      = 1'b0;
    emit_mask = pend_mask;
    emit_data = pend_data;
    emit_reg  = pend_reg;
    emit_addr = pend_waddr;
    if (conflict) begin
      // The old word leaves with its partial mask; the new byte opens a fresh word
      emit = 1'b1;
    end else if ((accept && (&merged_mask)) || (falling && (|merged_mask))) begin
      emit      = 1'b1;
      emit_mask = merged_mask;
      emit_data = merged_data;
      emit_reg  = accept ? in_reg   : pend_reg;
      emit_addr = accept ? in_waddr : pend_waddr;
    end else if ((state == FLUSH) && (|pend_mask)) begin
      emit = 1'b1;
    end
    next_mask = (emit && !conflict) ? '0 : merged_mask;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      dl_p1      <= 1'b0;
      start_pend <= 1'b0;
      pend_mask  <= '0;
      pend_reg   <= '0;
      pend_waddr <= '0;
      prog_we    <= '0;
      prog_addr  <= '0;
      prog_data  <= '0;
      prog_be    <= '0;
      dwnld_busy <= 1'b0;
      dwnld_done <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      dl_p1      <= downloading;
      prog_we    <= '0;
      dwnld_done <= 1'b0;
      if (emit) begin
        prog_we   <= REGIONS'(1) << emit_reg;
        prog_addr <= emit_addr;
        prog_data <= emit_data;
        prog_be   <= emit_mask;
      end
      case (state)
        IDLE: if (load_start) begin
          state      <= LOAD;
          dwnld_busy <= 1'b1;
          pend_mask  <= '0;
          overflow   <= 1'b0;
          start_pend <= 1'b0;
        end
        LOAD: begin
          pend_mask <= next_mask;
          if (accept) begin
            pend_reg   <= in_reg;
            pend_waddr <= in_waddr;
          end
          if (ioctl_wr && !in_range) overflow <= 1'b1;
          if (!downloading) state <= FLUSH;
        end
        FLUSH: begin
          pend_mask  <= '0;
          state      <= DONE;
          dwnld_done <= 1'b1;
          dwnld_busy <= 1'b0;
          if (rise) start_pend <= 1'b1;
        end
        default: begin
          state <= IDLE;
          if (rise) start_pend <= 1'b1;
        end
      endcase
    end
  end

  // Payload storage; lanes outside pend_mask are don't-care
  always_ff @(posedge clk) begin
    if (load_start)  pend_data <= '0;
    else if (accept) pend_data <= merged_data;
  end

`ifdef JTFRAME_DWNLD_CHECKSUM_EN
  logic [15:0] sum;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             sum <= '0;
    else if (load_start) sum <= '0;
    else if (accept)     sum <= sum + 16'(ioctl_data);
  end
  assign checksum = sum;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_jtframe_dwnld_split.sv
// Directed bench for jtframe_dwnld_split: a DW=16 and a DW=32 instance share one ioctl stream.
module tb_jtframe_dwnld_split;
  localparam int AW = 22;
  localparam logic [4*AW-1:0] ST = {22'h300, 22'h200, 22'h100, 22'h000};

  logic          clk = 1'b0, rst = 1'b1, downloading = 1'b0, ioctl_wr = 1'b0;
  logic [AW-1:0] ioctl_addr = '0;
  logic [7:0]    ioctl_data = '0;

  logic [3:0]    we16, we32;
  logic [AW-1:0] addr16, addr32;
  logic [15:0]   data16;
  logic [31:0]   data32;
  logic [1:0]    be16;
  logic [3:0]    be32;
  logic          busy16, busy32, done16, done32, ov16, ov32;
  logic [15:0]   cs16, cs32;

  jtframe_dwnld_split #(.REGIONS(4), .AW(AW), .DW(16), .START(ST), .TOTAL(22'h400)) dut16 (
    .clk(clk), .rst(rst), .downloading(downloading), .ioctl_addr(ioctl_addr),
    .ioctl_data(ioctl_data), .ioctl_wr(ioctl_wr), .prog_we(we16), .prog_addr(addr16),
    .prog_data(data16), .prog_be(be16), .dwnld_busy(busy16), .dwnld_done(done16),
    .overflow(ov16), .checksum(cs16));

  jtframe_dwnld_split #(.REGIONS(4), .AW(AW), .DW(32), .START(ST), .TOTAL(22'h400)) dut32 (
    .clk(clk), .rst(rst), .downloading(downloading), .ioctl_addr(ioctl_addr),
    .ioctl_data(ioctl_data), .ioctl_wr(ioctl_wr), .prog_we(we32), .prog_addr(addr32),
    .prog_data(data32), .prog_be(be32), .dwnld_busy(busy32), .dwnld_done(done32),
    .overflow(ov32), .checksum(cs32));

  always #5 clk = ~clk;

  // Write log for the 16-bit instance, write/done counts for the 32-bit one
  logic [3:0]    l16_we   [1024];
  logic [AW-1:0] l16_addr [1024];
  logic [15:0]   l16_data [1024];
  logic [1:0]    l16_be   [1024];
  int n16 = 0, n32 = 0, nd32 = 0;

  always @(negedge clk) begin
    if (|we16) begin
      if (n16 < 1024) begin
        l16_we[n16]   <= we16;
        l16_addr[n16] <= addr16;
        l16_data[n16] <= data16;
        l16_be[n16]   <= be16;
      end
      n16 <= n16 + 1;
    end
    if (|we32)  n32  <= n32 + 1;
    if (done32) nd32 <= nd32 + 1;
  end

  int nchk = 0, npass = 0, nfail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_byte(input logic [AW-1:0] a, input logic [7:0] d);
    ioctl_addr = a;
    ioctl_data = d;
    ioctl_wr   = 1'b1;
    tick();
    ioctl_wr   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b, b32, bd, bad;
    logic [15:0] cs_exp;
`ifdef JTFRAME_DWNLD_CHECKSUM_EN
    cs_exp = 16'hFE00;
`else
    cs_exp = 16'h0000;
`endif

    // Reset state
    tick(); tick();
    check("rst_we16",   64'(we16),   64'(0));
    check("rst_addr16", 64'(addr16), 64'(0));
    check("rst_data16", 64'(data16), 64'(0));
    check("rst_be16",   64'(be16),   64'(0));
    check("rst_busy16", 64'(busy16), 64'(0));
    check("rst_done16", 64'(done16), 64'(0));
    check("rst_ov16",   64'(ov16),   64'(0));
    check("rst_we32",   64'(we32),   64'(0));
    rst = 1'b0;
    tick();

    downloading = 1'b1;
    tick();
    check("busy_rise", 64'(busy16), 64'(1));

    // Packing: bytes 0..255, one every two cycles
    b = n16;
    for (int i = 0; i < 256; i++) begin
      wr_byte(AW'(i), 8'(i));
      tick();
    end
    check("pack_count", 64'(n16 - b), 64'(128));
    check("pack_we0",   64'(l16_we[b]),   64'(4'b0001));
    check("pack_addr0", 64'(l16_addr[b]), 64'(0));
    check("pack_data0", 64'(l16_data[b]), 64'(16'h0100));
    check("pack_be0",   64'(l16_be[b]),   64'(2'b11));
    bad = 0;
    for (int k = 0; k < 128; k++)
      if (l16_we[b+k] !== 4'b0001 || l16_addr[b+k] !== AW'(k) ||
          l16_data[b+k] !== {8'(2*k+1), 8'(2*k)}) bad++;
    check("pack_seq", 64'(bad), 64'(0));

    // Region boundary
    wr_byte(22'h0FF, 8'hAA);
    check("bnd_lone_we", 64'(we16), 64'(0));
    wr_byte(22'h100, 8'h55);
    check("bnd_we",   64'(we16),        64'(4'b0001));
    check("bnd_addr", 64'(addr16),      64'(22'h7F));
    check("bnd_be",   64'(be16),        64'(2'b10));
    check("bnd_hi",   64'(data16[15:8]), 64'(8'hAA));
    wr_byte(22'h101, 8'h66);
    check("r1_we",   64'(we16),   64'(4'b0010));
    check("r1_addr", 64'(addr16), 64'(0));
    check("r1_data", 64'(data16), 64'(16'h6655));
    check("r1_be",   64'(be16),   64'(2'b11));

    // End of download: 32-bit instance flushes the partial region-1 word
    downloading = 1'b0;
    tick();
    check("end_we16",   64'(we16),          64'(0));
    check("end_we32",   64'(we32),          64'(4'b0010));
    check("end_addr32", 64'(addr32),        64'(0));
    check("end_be32",   64'(be32),          64'(4'b0011));
    check("end_data32", 64'(data32[15:0]),  64'(16'h6655));
    check("end_done16_early", 64'(done16),  64'(0));
    tick();
    check("end_done16", 64'(done16), 64'(1));
    check("end_busy16", 64'(busy16), 64'(0));
    tick();
    check("end_done16_drop", 64'(done16), 64'(0));

    // Odd-length flush on DW=32
    downloading = 1'b1;
    tick(); tick();
    wr_byte(22'h0, 8'h10);
    wr_byte(22'h1, 8'h11);
    wr_byte(22'h2, 8'h12);
    wr_byte(22'h3, 8'h13);
    check("odd_full_we",   64'(we32),   64'(4'b0001));
    check("odd_full_addr", 64'(addr32), 64'(0));
    check("odd_full_be",   64'(be32),   64'(4'hF));
    check("odd_full_data", 64'(data32), 64'(32'h13121110));
    wr_byte(22'h4, 8'h14);
    check("odd_pend_we", 64'(we32), 64'(0));
    downloading = 1'b0;
    tick();
    check("flush_we",   64'(we32),         64'(4'b0001));
    check("flush_addr", 64'(addr32),       64'(1));
    check("flush_be",   64'(be32),         64'(4'h1));
    check("flush_b0",   64'(data32[7:0]),  64'(8'h14));
    check("flush_done_early", 64'(done32), 64'(0));
    tick();
    check("flush_done",   64'(done32), 64'(1));
    check("flush_busy",   64'(busy32), 64'(0));
    check("flush_we_off", 64'(we32),   64'(0));
    tick();
    check("flush_done_drop", 64'(done32), 64'(0));

    // Overflow
    downloading = 1'b1;
    tick();
    b = n16;
    wr_byte(22'h400, 8'h77);
    check("ovf_we",  64'(we16), 64'(0));
    check("ovf_set", 64'(ov16), 64'(1));
    tick(); tick();
    downloading = 1'b0;
    tick(); tick(); tick();
    check("ovf_sticky", 64'(ov16), 64'(1));
    check("ovf_nowr",   64'(n16 - b), 64'(0));
    downloading = 1'b1;
    tick();
    check("ovf_clear", 64'(ov16), 64'(0));

    // Reset mid-download
    b32 = n32;
    bd  = nd32;
    wr_byte(22'h0, 8'h01);
    wr_byte(22'h1, 8'h02);
    wr_byte(22'h2, 8'h03);
    rst = 1'b1;
    downloading = 1'b0;
    #1;
    check("mrst_we",   64'(we32),   64'(0));
    check("mrst_addr", 64'(addr32), 64'(0));
    check("mrst_data", 64'(data32), 64'(0));
    check("mrst_be",   64'(be32),   64'(0));
    check("mrst_busy", 64'(busy32), 64'(0));
    tick(); tick();
    rst = 1'b0;
    tick(); tick(); tick(); tick();
    check("mrst_nowr",   64'(n32 - b32), 64'(0));
    check("mrst_nodone", 64'(nd32 - bd), 64'(0));

    // Clean restart: a lone lane-3 byte must not complete a word
    downloading = 1'b1;
    tick();
    check("restart_busy", 64'(busy32), 64'(1));
    wr_byte(22'h3, 8'hA3);
    check("restart_lone", 64'(we32), 64'(0));
    wr_byte(22'h0, 8'hA0);
    wr_byte(22'h1, 8'hA1);
    wr_byte(22'h2, 8'hA2);
    check("restart_we",   64'(we32),   64'(4'b0001));
    check("restart_data", 64'(data32), 64'(32'hA3A2A1A0));
    downloading = 1'b0;
    tick(); tick(); tick();

    // Checksum over 512 bytes of 0xFF
    downloading = 1'b1;
    tick();
    for (int i = 0; i < 512; i++) wr_byte(AW'(i), 8'hFF);
    downloading = 1'b0;
    tick(); tick();
    check("cs_done", 64'(done16), 64'(1));
    check("cs16",    64'(cs16),   64'(cs_exp));
    check("cs32",    64'(cs32),   64'(cs_exp));
    tick();

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
